// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
// Operand classes, flag bit positions, exponent bias and canonical quiet NaN.
package fp_pkg;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_e;

  localparam int FLAGS_W = 4;
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NV = 3;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Positive quiet NaN: exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The producer/consumer side uses master, the multiplier uses slave.
interface fp_mul_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_a;
  logic [W-1:0]       in_b;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_result;
  logic [FLAGS_W-1:0] out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational operand classifier working on the exponent/mantissa fields.
// Subnormals are reported as zero (denormals-are-zero).
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] op_mag,
  output fp_class_e              cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = op_mag[EXP_W+MAN_W-1 -: EXP_W];
  assign man_f = op_mag[MAN_W-1:0];

  always_comb begin
    cls = FP_NORM;
    if (exp_f == '0) begin
      cls = FP_ZERO;
    end else if (&exp_f) begin
      if (man_f == '0)
        cls = FP_INF;
      else if (man_f[MAN_W-1])
        cls = FP_QNAN;
      else
        cls = FP_SNAN;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier, round-to-nearest-even, FTZ/DAZ,
// with valid/ready backpressure that collapses bubbles under stall.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic         clk,
  input logic         rst,
  fp_mul_pipe_if.slave bus
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * (MAN_W + 1);

  localparam logic [W-1:0]         QNAN      = W'(fp_canon_nan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] BIAS_S    = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << EXP_W) - 1);

  // Stage handshake: each stage can take new data if it is empty or its
  // successor is taking its current contents this cycle.
  logic v1_reg, v2_reg, v3_reg;
  logic ld1, ld2, ld3;

  assign ld3 = !v3_reg || bus.out_ready;
  assign ld2 = !v2_reg || ld3;
  assign ld1 = !v1_reg || ld2;

  assign bus.in_ready = ld1;

  // ---------------- S1: unpack, classify, exponent sum, product ----------
  logic [W-1:0] op  [2];
  fp_class_e    cls [2];

  assign op[0] = bus.in_a;
  assign op[1] = bus.in_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      fp_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
      ) u_classify (
        .op_mag (op[gi][W-2:0]),
        .cls    (cls[gi])
      );
    end
  endgenerate

  logic                   sign_s1;
  logic signed [EW-1:0]   e_s1;
  logic [PW-1:0]          prod_s1;
  logic                   spec_s1;
  logic [W-1:0]           spec_res_s1;
  logic [FLAGS_W-1:0]     spec_flags_s1;
  logic                   any_nan, any_snan, any_inf, any_zero;

  assign sign_s1  = op[0][W-1] ^ op[1][W-1];
  assign any_snan = (cls[0] == FP_SNAN) || (cls[1] == FP_SNAN);
  assign any_nan  = any_snan || (cls[0] == FP_QNAN) || (cls[1] == FP_QNAN);
  assign any_inf  = (cls[0] == FP_INF) || (cls[1] == FP_INF);
  assign any_zero = (cls[0] == FP_ZERO) || (cls[1] == FP_ZERO);

  assign e_s1 = $signed({2'b00, op[0][W-2 -: EXP_W]})
              + $signed({2'b00, op[1][W-2 -: EXP_W]}) - BIAS_S;
  assign prod_s1 = PW'({1'b1, op[0][MAN_W-1:0]}) * PW'({1'b1, op[1][MAN_W-1:0]});

  always_comb begin
    spec_s1       = 1'b1;
    spec_res_s1   = '0;
    spec_flags_s1 = '0;
    if (any_nan) begin
      spec_res_s1            = QNAN;
      spec_flags_s1[FLAG_NV] = any_snan;
    end else if (any_inf && any_zero) begin
      spec_res_s1            = QNAN;
      spec_flags_s1[FLAG_NV] = 1'b1;
    end else if (any_inf) begin
      spec_res_s1 = {sign_s1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      spec_res_s1 = {sign_s1, {(W-1){1'b0}}};
    end else begin
      spec_s1 = 1'b0;
    end
  end

  logic                 sign1_reg;
  logic signed [EW-1:0] e1_reg;
  logic [PW-1:0]        prod1_reg;
  logic                 spec1_reg;
  logic [W-1:0]         spec_res1_reg;
  logic [FLAGS_W-1:0]   spec_flags1_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg          <= 1'b0;
      sign1_reg       <= 1'b0;
      e1_reg          <= '0;
      prod1_reg       <= '0;
      spec1_reg       <= 1'b0;
      spec_res1_reg   <= '0;
      spec_flags1_reg <= '0;
    end else if (ld1) begin
      v1_reg <= bus.in_valid;
      if (bus.in_valid) begin
        sign1_reg       <= sign_s1;
        e1_reg          <= e_s1;
        prod1_reg       <= prod_s1;
        spec1_reg       <= spec_s1;
        spec_res1_reg   <= spec_res_s1;
        spec_flags1_reg <= spec_flags_s1;
      end
    end
  end

  // ---------------- S2: normalise, guard/sticky ---------------------------
  // After normalisation the hidden one sits at bit PW-1 and is dropped.
  logic [PW-2:0]        norm_s2;
  logic signed [EW-1:0] e_s2;
  logic [MAN_W-1:0]     man_s2;
  logic                 g_s2, st_s2;

  assign norm_s2 = prod1_reg[PW-1] ? prod1_reg[PW-2:0] : {prod1_reg[PW-3:0], 1'b0};
  assign e_s2    = e1_reg + EW'(prod1_reg[PW-1]);
  assign man_s2  = norm_s2[PW-2 -: MAN_W];
  assign g_s2    = norm_s2[MAN_W];
  assign st_s2   = |norm_s2[MAN_W-1:0];

  logic                 sign2_reg;
  logic signed [EW-1:0] e2_reg;
  logic [MAN_W-1:0]     man2_reg;
  logic                 g2_reg, st2_reg;
  logic                 spec2_reg;
  logic [W-1:0]         spec_res2_reg;
  logic [FLAGS_W-1:0]   spec_flags2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_reg          <= 1'b0;
      sign2_reg       <= 1'b0;
      e2_reg          <= '0;
      man2_reg        <= '0;
      g2_reg          <= 1'b0;
      st2_reg         <= 1'b0;
      spec2_reg       <= 1'b0;
      spec_res2_reg   <= '0;
      spec_flags2_reg <= '0;
    end else if (ld2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        sign2_reg       <= sign1_reg;
        e2_reg          <= e_s2;
        man2_reg        <= man_s2;
        g2_reg          <= g_s2;
        st2_reg         <= st_s2;
        spec2_reg       <= spec1_reg;
        spec_res2_reg   <= spec_res1_reg;
        spec_flags2_reg <= spec_flags1_reg;
      end
    end
  end

  // ---------------- S3: round, range check, pack -------------------------
  logic                 round_inc;
  logic [MAN_W:0]       man_sum;
  logic signed [EW-1:0] e_fin;
  logic                 nx_s3;
  logic [W-1:0]         res_s3;
  logic [FLAGS_W-1:0]   flags_s3;

  assign round_inc = g2_reg && (st2_reg || man2_reg[0]);
  assign man_sum   = {1'b0, man2_reg} + {{MAN_W{1'b0}}, round_inc};
  assign e_fin     = e2_reg + EW'(man_sum[MAN_W]);
  assign nx_s3     = g2_reg || st2_reg;

  always_comb begin
    res_s3   = '0;
    flags_s3 = '0;
    if (spec2_reg) begin
      res_s3   = spec_res2_reg;
      flags_s3 = spec_flags2_reg;
    end else if (e_fin >= EXP_MAX_S) begin
      res_s3            = {sign2_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_s3[FLAG_OF] = 1'b1;
      flags_s3[FLAG_NX] = 1'b1;
    end else if (e_fin[EW-1] || (e_fin == '0)) begin
      res_s3            = {sign2_reg, {(W-1){1'b0}}};
      flags_s3[FLAG_UF] = 1'b1;
      flags_s3[FLAG_NX] = 1'b1;
    end else begin
      res_s3            = {sign2_reg, e_fin[EXP_W-1:0], man_sum[MAN_W-1:0]};
      flags_s3[FLAG_NX] = nx_s3;
    end
  end

  logic [W-1:0]       res3_reg;
  logic [FLAGS_W-1:0] flags3_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_reg     <= 1'b0;
      res3_reg   <= '0;
      flags3_reg <= '0;
    end else if (ld3) begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        res3_reg   <= res_s3;
        flags3_reg <= flags_s3;
      end
    end
  end

  assign bus.out_valid  = v3_reg;
  assign bus.out_result = res3_reg;
  assign bus.out_flags  = flags3_reg;

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, fully pipelined IEEE-754 binary floating-point multiplier with a valid/ready handshake. It has configurable exponent and mantissa widths, round-to-nearest-even, exception flags and backpressure stall. It is the next-generation replacement for the fixed FP32 multiplier in the arithmetic datapath and sits between the operand issue logic and the result writeback FIFO.

## Interface
- `EXP_W`, default 8: exponent field width (≥4).
- `MAN_W`, default 23: stored mantissa width (≥4). Word width `W = 1+EXP_W+MAN_W`.
- `clk`  in  1: clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: block accepts operands this cycle.
- `in_a`, `in_b`  in  W: IEEE operands, `{sign, exp, man}`.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `out_result`  out  W: product.
- `out_flags`  out  4: `{nv, of, uf, nx}` (invalid, overflow, underflow, inexact).

## Operation
- Bias is `2^(EXP_W-1)-1`. Internal exponent is signed, `EXP_W+2` bits. Significand product is `2*(MAN_W+1)` bits.
- Classification per operand: zero (exp=0, including subnormals: DAZ, the subnormal is treated as signed zero), inf, qNaN/sNaN (exp all ones, man≠0; man MSB=1 means quiet), normal.
- Sign of result is `sa ^ sb` for every non-NaN result.
- Special results, priority order:
  - Any NaN operand → canonical qNaN `{0, all-ones, 1, 0…}`. nv=1 only if either operand is sNaN.
  - 0×inf → canonical qNaN, nv=1.
  - inf×x → signed inf, no flags.
  - 0×x → signed zero, no flags.
- Normal path:
  - `e = ea+eb-bias`.
  - If the product MSB is set, shift right 1 and `e+1`.
  - Guard bit = next bit below LSB; sticky = OR of the remainder.
  - RNE: increment if `g & (s | lsb)`. A mantissa carry-out on rounding gives `e+1` and man=0.
  - nx = `g|s`.
- Overflow, final `e ≥ 2^EXP_W-1` → signed inf, of=1, nx=1.
- Underflow, final `e ≤ 0` → signed zero (FTZ), uf=1, nx=1.
- Flags are per-result and non-sticky. They are valid only with `out_valid`.

## Timing
- Three stages:
  - S1: unpack, classify, exponent sum, significand product.
  - S2: normalise, guard/sticky extraction.
  - S3: round, overflow/underflow, pack.
- S3 registers drive the outputs directly.
- Latency is 3 cycles from the accept edge (`in_valid & in_ready`) to `out_valid` when there is no stall. Throughput is 1 result/cycle.
- Stage k loads when `!valid_{k+1}` or stage k+1 advances. S3 advances on `out_ready`.
- `in_ready = !v1 | adv1`. This is a combinational chain from `out_ready`. No bubbles are inserted under continuous flow.
- While `out_valid & !out_ready`: `out_result` and `out_flags` hold stable and no stage with a valid successor advances. Upstream bubbles may still collapse.
- Reset (async, any time, including mid-operation):
  - All stage valids are cleared; in-flight operations are discarded.
  - `out_valid=0`, `out_result=0`, `out_flags=0`.
  - `in_ready=1` from the first cycle after release.
- A data register is loaded only when its stage loads. Valid bits gate everything.

## Structure
- Package `fp_pkg`:
  - class enum `{FP_ZERO, FP_NORM, FP_INF, FP_QNAN, FP_SNAN}`;
  - flag bit indices;
  - functions for bias and canonical-NaN construction from `EXP_W`/`MAN_W`.
- One sub-module, `fp_classify`: combinational operand classifier, instantiated twice in S1.
- Rounding and packing stay inline in S3.

## Test plan
All values FP32 defaults.
- 0x40000000 × 0x40400000 → 0x40C00000, flags 0, after exactly 3 cycles. Then 0x3FC00000 × 0x3FC00000 on the next cycle → 0x40100000.
- RNE and inexact:
  - 0x3F800001 × 0x3F800001 → 0x3F800002, nx=1.
  - 0x3FFFFFFF × 0x3FFFFFFF → 0x407FFFFE, nx=1.
  - 0x3F800000 × 0x3F800000 → 0x3F800000, flags 0.
- Overflow and underflow:
  - 0x7F000000 × 0x40000000 → 0x7F800000, of=1, nx=1.
  - 0x80800000 × 0x3F000000 → 0x80000000, uf=1, nx=1.
- Specials:
  - 0x00000000 × 0xFF800000 → 0x7FC00000, nv=1.
  - 0x7F800001 × 0x3F800000 → 0x7FC00000, nv=1.
  - 0x7FC00000 × 0 → 0x7FC00000, nv=0.
  - 0x00000001 (subnormal) × 0x40000000 → 0x00000000, flags 0.
- Backpressure: stream 8 random operand pairs with `out_ready` toggled pseudo-randomly → results arrive in order, match the golden model, and outputs stay stable while stalled. `in_ready` drops only when all 3 stages are full and stalled.
- Reset mid-flight: assert `rst` asynchronously with 3 ops in flight → outputs 0 immediately and no stale result afterwards. The next op gives the correct result after 3 cycles.
